// File: rtl/rr_mux_stream.sv
// Registered N:1 stream mux with fixed-select and round-robin modes.
// Optional transfer counter port xfer_cnt enabled by RR_MUX_STREAM_STATS_EN.
module rr_mux_stream #(
   parameter int WIDTH = 16,
   parameter int NCH = 16,
   localparam int SEL_W = $clog2(NCH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NCH*WIDTH-1:0] in_data,
   input  logic [NCH-1:0]       in_valid,
   output logic [NCH-1:0]       in_ready,
   input  logic                 mode,
   input  logic [SEL_W-1:0]     sel,
   output logic [WIDTH-1:0]     out_data,
   output logic [SEL_W-1:0]     out_ch,
   output logic                 out_valid,
   input  logic                 out_ready
`ifdef RR_MUX_STREAM_STATS_EN
   ,
   output logic [15:0]          xfer_cnt
`endif
);

   logic             load;
   logic             hit;
   logic [SEL_W-1:0] grant;
   logic [SEL_W-1:0] rrgrant;
   logic             rrhit;
   logic [SEL_W-1:0] ptr;
   logic [WIDTH-1:0] word;

   assign load = !out_valid || out_ready;

   // Round-robin search starts at ptr and wraps once around all channels.
   always_comb begin
      int j;
      rrgrant = '0;
      rrhit   = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         j = int'(ptr) + i;
         if (j >= NCH) begin
            j = j - NCH;
         end
         if (!rrhit && in_valid[SEL_W'(j)]) begin
            rrhit   = 1'b1;
            rrgrant = SEL_W'(j);
         end
      end
   end

   always_comb begin
      grant = sel;
      hit   = 1'b0;
      if (mode) begin
         grant = rrgrant;
         hit   = rrhit;
      end else if (32'(sel) < NCH) begin
         hit = in_valid[sel];
      end
   end

   always_comb begin
      word = '0;
      for (int c = 0; c < NCH; c++) begin
         if (SEL_W'(c) == grant) begin
            word = in_data[c*WIDTH +: WIDTH];
         end
      end
   end

   assign in_ready = (load && hit && !rst) ? (NCH'(1) << grant) : '0;

   // An empty grant on a load cycle leaves data/channel untouched and only drops valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
         ptr       <= '0;
      end else if (load) begin
         if (hit) begin
            out_data  <= word;
            out_ch    <= grant;
            out_valid <= 1'b1;
            ptr       <= (32'(grant) == NCH - 1) ? '0 : grant + 1'b1;
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

`ifdef RR_MUX_STREAM_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         xfer_cnt <= '0;
      end else if (out_valid && out_ready) begin
         xfer_cnt <= xfer_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_rr_mux_stream.sv
// Self-checking bench for rr_mux_stream: directed scenarios plus random traffic
// compared against a transaction-level model of the mux.
module tb_rr_mux_stream;

   localparam int WIDTH = 16;
   localparam int NCH = 16;
   localparam int SEL_W = $clog2(NCH);

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NCH*WIDTH-1:0] in_data;
   logic [NCH-1:0]       in_valid;
   logic [NCH-1:0]       in_ready;
   logic                 mode;
   logic [SEL_W-1:0]     sel;
   logic [WIDTH-1:0]     out_data;
   logic [SEL_W-1:0]     out_ch;
   logic                 out_valid;
   logic                 out_ready;
`ifdef RR_MUX_STREAM_STATS_EN
   logic [15:0]          xfer_cnt;
`endif

   logic [WIDTH-1:0] chData [NCH];

   int checks = 0;
   int failures = 0;

   // Reference model state
   logic             mValid;
   logic [WIDTH-1:0] mData;
   int               mCh;
   int               mPtr;
   int               mCnt;

   always #5 clk = ~clk;

   always_comb begin
      for (int c = 0; c < NCH; c++) begin
         in_data[c*WIDTH +: WIDTH] = chData[c];
      end
   end

   rr_mux_stream #(.WIDTH(WIDTH), .NCH(NCH)) dut (
      .clk(clk),
      .rst(rst),
      .in_data(in_data),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .mode(mode),
      .sel(sel),
      .out_data(out_data),
      .out_ch(out_ch),
      .out_valid(out_valid),
      .out_ready(out_ready)
`ifdef RR_MUX_STREAM_STATS_EN
      ,
      .xfer_cnt(xfer_cnt)
`endif
   );

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Channel chosen by the arbitration rules, or -1 when nothing is granted.
   function automatic int pick(input logic m, input int s, input logic [NCH-1:0] v, input int p);
      if (!m) begin
         return (s < NCH && v[s]) ? s : -1;
      end
      for (int k = 0; k < NCH; k++) begin
         if (v[(p + k) % NCH]) begin
            return (p + k) % NCH;
         end
      end
      return -1;
   endfunction

   // One clock cycle: drive, check combinational ready, clock, update model, check outputs.
   task automatic applyStimulus(input logic r, input logic [NCH-1:0] v, input logic m,
                                input int s, input logic ordy);
      int g;
      logic ld;
      logic [NCH-1:0] expReady;
      rst = r;
      in_valid = v;
      mode = m;
      sel = SEL_W'(s);
      out_ready = ordy;
      #1;
      ld = !mValid || ordy;
      g = pick(m, s, v, mPtr);
      expReady = '0;
      if (!r && ld && g >= 0) begin
         expReady[g] = 1'b1;
      end
      checkOutput("in_ready", 32'(in_ready), 32'(expReady));
      @(posedge clk);
      if (r) begin
         mValid = 1'b0;
         mData = '0;
         mCh = 0;
         mPtr = 0;
         mCnt = 0;
      end else begin
         if (mValid && ordy) begin
            mCnt = (mCnt + 1) % 65536;
         end
         if (ld) begin
            if (g >= 0) begin
               mData = chData[g];
               mCh = g;
               mValid = 1'b1;
               mPtr = (g + 1) % NCH;
            end else begin
               mValid = 1'b0;
            end
         end
      end
      #1;
      checkOutput("out_valid", 32'(out_valid), 32'(mValid));
      checkOutput("out_data", 32'(out_data), 32'(mData));
      checkOutput("out_ch", 32'(out_ch), 32'(mCh));
`ifdef RR_MUX_STREAM_STATS_EN
      checkOutput("xfer_cnt", 32'(xfer_cnt), 32'(mCnt));
`endif
      @(negedge clk);
   endtask

   initial begin
      int sweep [NCH] = '{1212, 23, 0, 432, 51, 61, 17, 38, 3, 140, 111, 124, 113, 14, 155, 165};
      int rrSeq [6] = '{0, 3, 7, 0, 3, 7};
      logic [NCH-1:0] v;

      mValid = 1'b0; mData = '0; mCh = 0; mPtr = 0; mCnt = 0;
      rst = 1'b1; in_valid = '1; mode = 1'b0; sel = '0; out_ready = 1'b1;
      for (int c = 0; c < NCH; c++) chData[c] = WIDTH'(sweep[c]);
      @(negedge clk);

      // Reset held with every channel requesting
      applyStimulus(1'b1, '1, 1'b0, 0, 1'b1);
      applyStimulus(1'b1, '1, 1'b1, 0, 1'b1);
      checkOutput("reset_out_valid", 32'(out_valid), 32'd0);

      // Fixed-select sweep across all channels
      for (int s = 0; s < NCH; s++) begin
         applyStimulus(1'b0, '1, 1'b0, s, 1'b1);
         checkOutput("sweep_data", 32'(out_data), 32'(sweep[s]));
      end

      // Round-robin over channels 0, 3, 7
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b0, 16'h0089, 1'b1, 0, 1'b1);
         checkOutput("rr_ch", 32'(out_ch), 32'(rrSeq[i]));
      end

      // Backpressure on word 51 from channel 4
      applyStimulus(1'b0, '1, 1'b0, 4, 1'b1);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, '1, 1'b0, 5, 1'b0);
         checkOutput("bp_hold", 32'(out_data), 32'd51);
      end
      applyStimulus(1'b0, '1, 1'b0, 5, 1'b1);
      checkOutput("bp_next", 32'(out_data), 32'd61);

      // Bubble, then an idle selected channel
      applyStimulus(1'b0, '0, 1'b0, 5, 1'b1);
      checkOutput("bubble_data", 32'(out_data), 32'd61);
      applyStimulus(1'b0, 16'h7fff, 1'b0, 15, 1'b1);
      checkOutput("idle_valid", 32'(out_valid), 32'd0);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         for (int c = 0; c < NCH; c++) chData[c] = WIDTH'($urandom);
         v = NCH'($urandom);
         if ($urandom_range(0, 3) == 0) v = v & NCH'($urandom);
         applyStimulus(($urandom_range(0, 63) == 0), v, 1'(($urandom_range(0, 1))),
                       int'($urandom_range(0, NCH - 1)), ($urandom_range(0, 3) != 0));
      end

`ifdef RR_MUX_STREAM_STATS_EN
      // Counter wrap: 65537 transfers after a fresh reset
      applyStimulus(1'b1, '1, 1'b1, 0, 1'b1);
      for (int i = 0; i < 65538; i++) begin
         applyStimulus(1'b0, '1, 1'b1, 0, 1'b1);
      end
      checkOutput("cnt_wrap", 32'(xfer_cnt), 32'd1);
      applyStimulus(1'b1, '1, 1'b1, 0, 1'b1);
      checkOutput("cnt_reset", 32'(xfer_cnt), 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
